// File: rtl/wb_mem_responder_pkg.sv
// Shared definitions for the Wishbone memory responder: FSM encodings,
// bus widths, default window base and a byte-lane mask helper.
package wb_mem_responder_pkg;

  localparam int          WB_DW             = 32;
  localparam int          WB_SW             = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

  // Expand a 4-bit select into a 32-bit mask: lane n covers bits [8n+7:8n].
  function automatic logic [WB_DW-1:0] lane_mask(input logic [WB_SW-1:0] sel);
    logic [WB_DW-1:0] m;
    m = '0;
    for (int i = 0; i < WB_SW; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_mem_responder_ram.sv
// Synchronous single-port RAM with per-byte write enables and a registered
// read. Stored as four byte-wide arrays so each lane maps onto its own
// block-RAM column. Contents are never reset.
module wb_mem_responder_ram
  import wb_mem_responder_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [WB_SW-1:0] be,
  input  logic [AW-1:0]    addr,
  input  logic [WB_DW-1:0] wdata,
  output logic [WB_DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  for (genvar gi = 0; gi < WB_SW; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;

    // Byte lane: write when enabled and selected; read is old-data registered.
    always_ff @(posedge clk) begin
      if (en) begin
        if (we && be[gi]) begin
          mem[addr] <= wdata[8*gi +: 8];
        end
        q_reg <= mem[addr];
      end
    end

    assign rdata[8*gi +: 8] = q_reg;
  end

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B3 classic-cycle responder backed by a byte-lane RAM.
// One transaction in flight; IDLE -> (WAIT) -> RESP -> IDLE.
// Optional feature macro WB_RESP_ERR_EN: out-of-window addresses terminate
// with wb_err_o instead of aliasing into the RAM.
module wb_mem_responder
  import wb_mem_responder_pkg::*;
#(
  parameter int          AW          = 10,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_STATES = 0
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  // The wait counter is only 4 bits wide.
  if (WAIT_STATES > 15) begin : g_bad_wait_states
    $error("wb_mem_responder: WAIT_STATES=%0d exceeds 15", WAIT_STATES);
  end

  localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  wb_state_t        state_reg;
  logic [3:0]       count_reg;
  logic [31:0]      adr_reg;
  logic [31:0]      dat_reg;
  logic [3:0]       sel_reg;
  logic             we_reg;
  logic             ack_reg;
  logic             err_reg;

  logic             start;
  logic [31:0]      req_adr;
  logic [31:0]      req_dat;
  logic [3:0]       req_sel;
  logic             req_we;
  logic             hit;
  logic             enter_resp;
  logic [31:0]      ram_rdata;
  logic             unused_adr_bits;

  assign start = (state_reg == ST_IDLE) && wb_cyc_i && wb_stb_i;

  // With zero wait states the RAM is accessed on the accepting edge, so
  // the request must come straight from the bus rather than the latches.
  assign req_adr = (state_reg == ST_IDLE) ? wb_adr_i : adr_reg;
  assign req_dat = (state_reg == ST_IDLE) ? wb_dat_i : dat_reg;
  assign req_sel = (state_reg == ST_IDLE) ? wb_sel_i : sel_reg;
  assign req_we  = (state_reg == ST_IDLE) ? wb_we_i  : we_reg;

`ifdef WB_RESP_ERR_EN
  assign hit = (req_adr[31:AW+2] == BASE_ADDR[31:AW+2]);
`else
  assign hit = 1'b1;
`endif

  assign unused_adr_bits = ^{req_adr[1:0], req_adr[31:AW+2]};

  // RAM access happens exactly on the edge that moves into RESP.
  assign enter_resp = (start && (WAIT_STATES == 0)) ||
                      ((state_reg == ST_WAIT) && wb_cyc_i && (count_reg == 4'd0));

  wb_mem_responder_ram #(
    .AW (AW)
  ) u_ram (
    .clk   (wb_clk),
    .en    (enter_resp && hit),
    .we    (req_we),
    .be    (req_sel),
    .addr  (req_adr[AW+1:2]),
    .wdata (req_dat),
    .rdata (ram_rdata)
  );

  // Transaction FSM with registered ack/err terminations.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_reg <= ST_IDLE;
      count_reg <= 4'd0;
      adr_reg   <= '0;
      dat_reg   <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          ack_reg <= 1'b0;
          err_reg <= 1'b0;
          if (start) begin
            adr_reg <= wb_adr_i;
            dat_reg <= wb_dat_i;
            sel_reg <= wb_sel_i;
            we_reg  <= wb_we_i;
            if (WAIT_STATES == 0) begin
              state_reg <= ST_RESP;
              ack_reg   <= hit;
              err_reg   <= !hit;
            end else begin
              state_reg <= ST_WAIT;
              count_reg <= WS_M1[3:0];
            end
          end
        end
        ST_WAIT: begin
          if (!wb_cyc_i) begin
            state_reg <= ST_IDLE;
            count_reg <= 4'd0;
          end else if (count_reg == 4'd0) begin
            state_reg <= ST_RESP;
            ack_reg   <= hit;
            err_reg   <= !hit;
          end else begin
            count_reg <= count_reg - 4'd1;
          end
        end
        ST_RESP: begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Read data is only presented during a read ack; disabled lanes are zero.
  assign wb_dat_o = (ack_reg && !we_reg) ? (ram_rdata & lane_mask(sel_reg)) : 32'h0;
  assign wb_ack_o = ack_reg;
`ifdef WB_RESP_ERR_EN
  assign wb_err_o = err_reg;
`else
  assign wb_err_o = 1'b0 & err_reg;
`endif

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances (WS=0/AW=10, WS=3/AW=10,
// WS=0/AW=4) share one stimulus bus; cyc/stb are routed to the selected one.
module tb_wb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  int          tgt;

  logic [31:0] dat0, dat1, dat2;
  logic        ack0, ack1, ack2, err0, err1, err2;
  logic [31:0] cur_dat;
  logic        cur_ack, cur_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_mem_responder #(.AW(10), .WAIT_STATES(0)) dut0 (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc && tgt == 0), .wb_stb_i(stb && tgt == 0),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0));

  wb_mem_responder #(.AW(10), .WAIT_STATES(3)) dut3 (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc && tgt == 1), .wb_stb_i(stb && tgt == 1),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1));

  wb_mem_responder #(.AW(4), .WAIT_STATES(0)) dut_small (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc && tgt == 2), .wb_stb_i(stb && tgt == 2),
    .wb_dat_o(dat2), .wb_ack_o(ack2), .wb_err_o(err2));

  always_comb begin
    cur_dat = dat0;
    cur_ack = ack0;
    cur_err = err0;
    if (tgt == 1) begin
      cur_dat = dat1; cur_ack = ack1; cur_err = err1;
    end else if (tgt == 2) begin
      cur_dat = dat2; cur_ack = ack2; cur_err = err2;
    end
  end

  typedef struct {
    string       name;
    int          tgt;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
    logic        exp_ack;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input int t, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic [31:0] ed,
                     input logic ea, input logic ee, input int ec);
    vec_t v;
    v.name = n; v.tgt = t; v.we = w; v.adr = a; v.dat = d; v.sel = s;
    v.exp_dat = ed; v.exp_ack = ea; v.exp_err = ee; v.exp_cyc = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", n, act, exp);
    end
  endtask

  // One complete classic cycle; returns what the termination looked like.
  task automatic xfer(input int t, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic got_ack,
                      output logic got_err, output int ncyc);
    @(negedge clk);
    tgt = t; adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    ncyc = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
    while (ncyc < 30 && !got_ack && !got_err) begin
      @(posedge clk); #1;
      ncyc++;
      if (cur_ack || cur_err) begin
        got_ack = cur_ack; got_err = cur_err; rd = cur_dat;
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("single_cycle_term", {30'd0, cur_ack, cur_err}, 32'd0);
    chk("dat_idle_zero", cur_dat, 32'd0);
  endtask

  // Start a request, pull cyc (or reset) after two edges, and watch for acks.
  task automatic interrupted(input logic use_rst, input logic [31:0] a, input logic [31:0] d);
    int seen;
    seen = 0;
    @(negedge clk);
    tgt = 1; adr = a; dat = d; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (cur_ack || cur_err) seen++;
    end
    @(negedge clk);
    if (use_rst) begin
      rst = 1'b1;
      #1;
      chk("reset_immediate_term", {30'd0, cur_ack, cur_err}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (cur_ack || cur_err) seen++;
    end
    chk(use_rst ? "reset_no_ack" : "abort_no_ack", seen, 0);
    $display("%s adr=%h: terminations seen=%0d", use_rst ? "RESET" : "ABORT", a, seen);
  endtask

  localparam logic [31:0] MISS_RD_DAT = 32'hA5A5_A5A5;

  initial begin
    logic [31:0] rd;
    logic        ga, ge;
    int          nc;
    logic [31:0] miss_dat;
    logic        miss_ack, miss_err;
    logic [31:0] w1_after;

`ifdef WB_RESP_ERR_EN
    miss_dat = 32'h0; miss_ack = 1'b0; miss_err = 1'b1; w1_after = 32'h7777_8888;
`else
    miss_dat = MISS_RD_DAT; miss_ack = 1'b1; miss_err = 1'b0; w1_after = 32'hFFFF_FFFF;
`endif

    //    name          tgt we adr        dat            sel   exp_dat        ack err cyc
    add("wr_deadbeef",  0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,          1, 0, 1);
    add("rd_deadbeef",  0, 0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF,   1, 0, 1);
    add("wr_full_20",   0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0,          1, 0, 1);
    add("wr_lanes_20",  0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0,          1, 0, 1);
    add("rd_merged_20", 0, 0, 32'h20, 32'h0,        4'hF, 32'h11BB33DD,   1, 0, 1);
    add("rd_low_lanes", 0, 0, 32'h20, 32'h0,        4'h3, 32'h000033DD,   1, 0, 1);
    add("wr_full_24",   0, 1, 32'h24, 32'hCAFEF00D, 4'hF, 32'h0,          1, 0, 1);
    add("wr_sel0_24",   0, 1, 32'h24, 32'h12345678, 4'h0, 32'h0,          1, 0, 1);
    add("rd_after_sel0",0, 0, 32'h24, 32'h0,        4'hF, 32'hCAFEF00D,   1, 0, 1);
    add("ws3_wr_10",    1, 1, 32'h10, 32'h01020304, 4'hF, 32'h0,          1, 0, 4);
    add("ws3_rd_10",    1, 0, 32'h10, 32'h0,        4'hF, 32'h01020304,   1, 0, 4);
    add("ws3_wr_30",    1, 1, 32'h30, 32'h0BADF00D, 4'hF, 32'h0,          1, 0, 4);
    add("aw4_wr_w0",    2, 1, 32'h00, MISS_RD_DAT,  4'hF, 32'h0,          1, 0, 1);
    add("aw4_wr_w1",    2, 1, 32'h04, 32'h77778888, 4'hF, 32'h0,          1, 0, 1);
    add("aw4_rd_miss",  2, 0, 32'h40, 32'h0,        4'hF, miss_dat,       miss_ack, miss_err, 1);
    add("aw4_wr_miss",  2, 1, 32'h44, 32'hFFFFFFFF, 4'hF, 32'h0,          miss_ack, miss_err, 1);
    add("aw4_rd_w1",    2, 0, 32'h04, 32'h0,        4'hF, w1_after,       1, 0, 1);

    rst = 1'b1; tgt = 0; adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack_err", {26'd0, ack0, ack1, ack2, err0, err1, err2}, 32'd0);
    chk("reset_dat", dat0 | dat1 | dat2, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      xfer(vecs[i].tgt, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, ga, ge, nc);
      $display("%-14s dut=%0d we=%0d adr=%h sel=%h -> ack=%0d err=%0d dat=%h cycles=%0d",
               vecs[i].name, vecs[i].tgt, vecs[i].we, vecs[i].adr, vecs[i].sel, ga, ge, rd, nc);
      chk({vecs[i].name, "_ack"}, {31'd0, ga}, {31'd0, vecs[i].exp_ack});
      chk({vecs[i].name, "_err"}, {31'd0, ge}, {31'd0, vecs[i].exp_err});
      chk({vecs[i].name, "_cycles"}, nc, vecs[i].exp_cyc);
      if (!vecs[i].we) chk({vecs[i].name, "_dat"}, rd, vecs[i].exp_dat);
    end

    // Abort in WAIT: write must not land.
    interrupted(1'b0, 32'h30, 32'h5555AAAA);
    xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, rd, ga, ge, nc);
    $display("after_abort    dut=1 rd adr=00000030 -> ack=%0d dat=%h cycles=%0d", ga, rd, nc);
    chk("after_abort_dat", rd, 32'h0BADF00D);
    chk("after_abort_cycles", nc, 4);

    // Reset in WAIT: pending write discarded, next requests complete normally.
    interrupted(1'b1, 32'h30, 32'hFFFFFFFF);
    xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, rd, ga, ge, nc);
    $display("after_reset    dut=1 rd adr=00000030 -> ack=%0d dat=%h cycles=%0d", ga, rd, nc);
    chk("after_reset_ack", {31'd0, ga}, 32'd1);
    chk("after_reset_dat", rd, 32'h0BADF00D);
    chk("after_reset_cycles", nc, 4);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, ga, ge, nc);
    $display("after_reset    dut=0 rd adr=00000010 -> ack=%0d dat=%h cycles=%0d", ga, rd, nc);
    chk("after_reset_ws0_dat", rd, 32'hDEADBEEF);
    chk("after_reset_ws0_cycles", nc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
